axi_addr_window_guard: RTL and testbench
========================================

AXI_ADDR_WINDOW_GUARD -- requirements
Module: axi_addr_window_guard

Interface
REQ-001 SHALL have parameter AxiAddrWidth, default 32, meaning AW/AR address width.
REQ-002 SHALL have parameter AxiIdWidth, default 4, meaning AW/AR/B/R ID width.
REQ-003 SHALL have parameter MaxWrTxns, default 8, meaning max forwarded writes awaiting B.
REQ-004 SHALL have parameter MaxRdTxns, default 8, meaning max forwarded reads awaiting R last.
REQ-005 SHALL have type parameters rule_t (fields start_addr, end_addr), slv_req_t, slv_resp_t, mst_req_t, mst_resp_t, defaults axi_pkg::xbar_rule_64_t and logic.
REQ-006 SHALL have ports: clk_i in 1 clock; rst_i in 1 reset; slv_req_i in slv_req_t upstream request; slv_rsp_o out slv_resp_t upstream response; mst_req_o out mst_req_t to the downstream offset stage; mst_rsp_i in mst_resp_t downstream response; addr_map_i in rule_t window.
REQ-007 SHALL use one clock (clk_i, rising edge); reset rst_i is synchronous and active-high.

Function
REQ-008 SHALL decode an address as in-window iff start_addr <= addr < end_addr, unsigned, full AxiAddrWidth.
REQ-009 SHALL forward all AW/W/AR payload fields unmodified; no address translation.
REQ-010 SHALL run write FSM W_IDLE, W_FWD, W_ERR_DATA, W_ERR_RESP.
REQ-011 W_IDLE, in-window AW: mst aw_valid = slv aw_valid and slv aw_ready = mst aw_ready, both gated 0 while wr_cnt == MaxWrTxns; on handshake -> W_FWD, wr_cnt+1.
REQ-012 W_IDLE, out-of-window AW: mst aw_valid=0, slv aw_ready=1; capture aw.id; -> W_ERR_DATA.
REQ-013 W_FWD: W channel wired through; on w_last handshake -> W_IDLE; W gated (mst w_valid=0, slv w_ready=0) in every other state.
REQ-014 W_ERR_DATA: slv w_ready=1, beats discarded; on w_last handshake -> W_ERR_RESP.
REQ-015 W_ERR_RESP: while wr_cnt != 0 master B passes through; at wr_cnt == 0 drive slv b_valid=1, b.resp=2'b11 (DECERR), b.id=captured, b.user=0, mst b_ready=0; on b_ready -> W_IDLE.
REQ-016 Outside local B, B channel wired through; wr_cnt-1 on each master B handshake.
REQ-017 SHALL run read FSM R_IDLE, R_ERR.
REQ-018 R_IDLE, in-window AR: pass through, gated 0 while rd_cnt == MaxRdTxns; rd_cnt+1 on handshake; R wired through, rd_cnt-1 on R handshake with r.last=1.
REQ-019 R_IDLE, out-of-window AR: slv ar_ready=0 until rd_cnt == 0, then ar_ready=1; capture id and len; beat counter=0; -> R_ERR.
REQ-020 R_ERR: ar_ready=0, mst r_ready=0; drive r_valid=1, r.data=0, r.resp=2'b11, r.id=captured, r.user=0, r.last=(beat==len); beat+1 per handshake; after last handshake -> R_IDLE.
REQ-021 Counter increment and decrement in the same cycle SHALL leave the counter unchanged; counters never wrap.
REQ-022 Forwarding paths SHALL be combinational (zero latency); local B/R SHALL be asserted no earlier than the cycle after the triggering AW-last-W/AR handshake.
REQ-023 Write and read FSMs SHALL operate independently and concurrently.
REQ-024 aw.atop SHALL be forwarded; out-of-window ATOPs get B only (no R); ATOP traffic is outside verified scope.

Reset
REQ-025 With rst_i high at a clk_i edge: both FSMs -> IDLE, wr_cnt=rd_cnt=0, captured id/len/beat=0.
REQ-026 While rst_i high, all valid and ready outputs on both ports SHALL be 0; reset mid-burst abandons the burst with no B/R issued.

Verification
REQ-027 Window [0x1000_0000, 0x2000_0000): AW 0x1000_0040 len=3 id=2 -> forwarded, 4 W beats forwarded, downstream B OKAY id=2 returned upstream, wr_cnt 1 -> 0.
REQ-028 AW 0x2000_0000 len=1 id=5 -> master sees no AW/W, 2 beats absorbed, upstream B DECERR id=5 one cycle after last W.
REQ-029 AR 0x0FFF_FFFC len=2 id=7 -> 3 local R beats, data 0, DECERR, id=7, last on beat 3 only; r_ready low 1 cycle -> beat held.
REQ-030 In-window AR len=0 outstanding, then out-of-window AR -> error AR not accepted until downstream R last handshake.
REQ-031 MaxWrTxns=2: three in-window AWs without B -> third stalls (aw_ready=0) until a B handshake; B and AW handshake same cycle -> wr_cnt unchanged.
REQ-032 Assert rst_i during W_ERR_DATA -> next cycle all valids/readys 0, FSMs IDLE, no DECERR B produced.

Source files
------------

// File: rtl/axi_addr_window_guard.sv
// ============================================================================
// Module   : axi_addr_window_guard
// Brief    : Passes AXI bursts inside one address window and answers bursts
//            outside it locally with DECERR.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_pkg;
    typedef struct packed {
        logic [31:0] idx;
        logic [63:0] start_addr;
        logic [63:0] end_addr;
    } xbar_rule_64_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [5:0]  atop;
        logic [0:0]  user;
    } aw_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
        logic [0:0]  user;
    } w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
        logic [0:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [0:0]  user;
    } ar_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [0:0]  user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     ar_ready;
        logic     w_ready;
        logic     b_valid;
        b_chan_t  b;
        logic     r_valid;
        r_chan_t  r;
    } axi_resp_t;
endpackage

module axi_addr_window_guard #(
    parameter int unsigned AxiAddrWidth = 32,
    parameter int unsigned AxiIdWidth   = 4,
    parameter int unsigned MaxWrTxns    = 8,
    parameter int unsigned MaxRdTxns    = 8,
    parameter type rule_t     = axi_pkg::xbar_rule_64_t,
    parameter type slv_req_t  = axi_pkg::axi_req_t,
    parameter type slv_resp_t = axi_pkg::axi_resp_t,
    parameter type mst_req_t  = axi_pkg::axi_req_t,
    parameter type mst_resp_t = axi_pkg::axi_resp_t
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  slv_req_t  slv_req_i,
    output slv_resp_t slv_rsp_o,
    output mst_req_t  mst_req_o,
    input  mst_resp_t mst_rsp_i,
    input  rule_t     addr_map_i
);

    localparam int unsigned c_WR_CNT_W = $clog2(MaxWrTxns + 1);
    localparam int unsigned c_RD_CNT_W = $clog2(MaxRdTxns + 1);
    localparam logic [c_WR_CNT_W-1:0] c_WR_MAX = c_WR_CNT_W'(MaxWrTxns);
    localparam logic [c_RD_CNT_W-1:0] c_RD_MAX = c_RD_CNT_W'(MaxRdTxns);
    localparam logic [1:0] c_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE     = 2'd0,
        W_FWD      = 2'd1,
        W_ERR_DATA = 2'd2,
        W_ERR_RESP = 2'd3
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_ERR  = 1'b1
    } rd_state_t;

    wr_state_t r_wr_state, w_wr_state_nxt;
    rd_state_t r_rd_state, w_rd_state_nxt;

    logic [c_WR_CNT_W-1:0] r_wr_cnt;
    logic [c_RD_CNT_W-1:0] r_rd_cnt;
    logic [AxiIdWidth-1:0] r_b_id;
    logic [AxiIdWidth-1:0] r_r_id;
    logic [7:0]            r_r_len;
    logic [7:0]            r_r_beat;

    logic [AxiAddrWidth-1:0] w_start;
    logic [AxiAddrWidth-1:0] w_end;
    logic w_aw_in, w_ar_in;
    logic w_aw_valid, w_aw_ready, w_w_valid, w_w_ready, w_b_local, w_aw_err_acc;
    logic w_ar_valid, w_ar_ready, w_r_local, w_ar_err_acc;
    logic w_wr_inc, w_wr_dec, w_rd_inc, w_rd_dec;
    logic w_unused_rule;

    assign w_start = addr_map_i.start_addr[AxiAddrWidth-1:0];
    assign w_end   = addr_map_i.end_addr[AxiAddrWidth-1:0];
    assign w_aw_in = (slv_req_i.aw.addr >= w_start) && (slv_req_i.aw.addr < w_end);
    assign w_ar_in = (slv_req_i.ar.addr >= w_start) && (slv_req_i.ar.addr < w_end);
    assign w_unused_rule = ^addr_map_i;

    // Write path: forwarded bursts pass straight through, rejected ones are drained here.
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_aw_valid     = 1'b0;
        w_aw_ready     = 1'b0;
        w_w_valid      = 1'b0;
        w_w_ready      = 1'b0;
        w_b_local      = 1'b0;
        w_aw_err_acc   = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                if (slv_req_i.aw_valid) begin
                    if (w_aw_in) begin
                        if (r_wr_cnt != c_WR_MAX) begin
                            w_aw_valid = 1'b1;
                            w_aw_ready = mst_rsp_i.aw_ready;
                            if (mst_rsp_i.aw_ready) begin
                                w_wr_state_nxt = W_FWD;
                            end
                        end
                    end else begin
                        w_aw_ready     = 1'b1;
                        w_aw_err_acc   = 1'b1;
                        w_wr_state_nxt = W_ERR_DATA;
                    end
                end
            end
            W_FWD: begin
                w_w_valid = slv_req_i.w_valid;
                w_w_ready = mst_rsp_i.w_ready;
                if (slv_req_i.w_valid && mst_rsp_i.w_ready && slv_req_i.w.last) begin
                    w_wr_state_nxt = W_IDLE;
                end
            end
            W_ERR_DATA: begin
                w_w_ready = 1'b1;
                if (slv_req_i.w_valid && slv_req_i.w.last) begin
                    w_wr_state_nxt = W_ERR_RESP;
                end
            end
            W_ERR_RESP: begin
                // Hold the DECERR back until every forwarded B has drained, keeping B order.
                if (r_wr_cnt == '0) begin
                    w_b_local = 1'b1;
                    if (slv_req_i.b_ready) begin
                        w_wr_state_nxt = W_IDLE;
                    end
                end
            end
        endcase
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_ar_valid     = 1'b0;
        w_ar_ready     = 1'b0;
        w_r_local      = 1'b0;
        w_ar_err_acc   = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                if (slv_req_i.ar_valid) begin
                    if (w_ar_in) begin
                        if (r_rd_cnt != c_RD_MAX) begin
                            w_ar_valid = 1'b1;
                            w_ar_ready = mst_rsp_i.ar_ready;
                        end
                    end else if (r_rd_cnt == '0) begin
                        w_ar_ready     = 1'b1;
                        w_ar_err_acc   = 1'b1;
                        w_rd_state_nxt = R_ERR;
                    end
                end
            end
            R_ERR: begin
                w_r_local = 1'b1;
                if (slv_req_i.r_ready && (r_r_beat == r_r_len)) begin
                    w_rd_state_nxt = R_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        mst_req_o          = slv_req_i;
        mst_req_o.aw_valid = w_aw_valid & ~rst_i;
        mst_req_o.w_valid  = w_w_valid & ~rst_i;
        mst_req_o.b_ready  = slv_req_i.b_ready & ~w_b_local & ~rst_i;
        mst_req_o.ar_valid = w_ar_valid & ~rst_i;
        mst_req_o.r_ready  = slv_req_i.r_ready & ~w_r_local & ~rst_i;

        slv_rsp_o          = mst_rsp_i;
        slv_rsp_o.aw_ready = w_aw_ready & ~rst_i;
        slv_rsp_o.w_ready  = w_w_ready & ~rst_i;
        slv_rsp_o.ar_ready = w_ar_ready & ~rst_i;
        slv_rsp_o.b_valid  = (w_b_local | mst_rsp_i.b_valid) & ~rst_i;
        slv_rsp_o.r_valid  = (w_r_local | mst_rsp_i.r_valid) & ~rst_i;
        if (w_b_local) begin
            slv_rsp_o.b.id   = r_b_id;
            slv_rsp_o.b.resp = c_DECERR;
            slv_rsp_o.b.user = '0;
        end
        if (w_r_local) begin
            slv_rsp_o.r.id   = r_r_id;
            slv_rsp_o.r.data = '0;
            slv_rsp_o.r.resp = c_DECERR;
            slv_rsp_o.r.last = (r_r_beat == r_r_len);
            slv_rsp_o.r.user = '0;
        end
    end

    assign w_wr_inc = w_aw_valid & mst_rsp_i.aw_ready & ~rst_i;
    assign w_wr_dec = mst_rsp_i.b_valid & slv_req_i.b_ready & ~w_b_local & ~rst_i;
    assign w_rd_inc = w_ar_valid & mst_rsp_i.ar_ready & ~rst_i;
    assign w_rd_dec = mst_rsp_i.r_valid & mst_rsp_i.r.last & slv_req_i.r_ready & ~w_r_local & ~rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_state <= W_IDLE;
            r_rd_state <= R_IDLE;
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_b_id     <= '0;
            r_r_id     <= '0;
            r_r_len    <= '0;
            r_r_beat   <= '0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_rd_state <= w_rd_state_nxt;

            if (w_wr_inc && !w_wr_dec) begin
                r_wr_cnt <= r_wr_cnt + c_WR_CNT_W'(1);
            end else if (w_wr_dec && !w_wr_inc && (r_wr_cnt != '0)) begin
                r_wr_cnt <= r_wr_cnt - c_WR_CNT_W'(1);
            end

            if (w_rd_inc && !w_rd_dec) begin
                r_rd_cnt <= r_rd_cnt + c_RD_CNT_W'(1);
            end else if (w_rd_dec && !w_rd_inc && (r_rd_cnt != '0)) begin
                r_rd_cnt <= r_rd_cnt - c_RD_CNT_W'(1);
            end

            if (w_aw_err_acc) begin
                r_b_id <= slv_req_i.aw.id;
            end

            if (w_ar_err_acc) begin
                r_r_id   <= slv_req_i.ar.id;
                r_r_len  <= slv_req_i.ar.len;
                r_r_beat <= '0;
            end else if (w_r_local && slv_req_i.r_ready) begin
                r_r_beat <= r_r_beat + 8'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axi_addr_window_guard.sv
// ============================================================================
// Module   : tb_axi_addr_window_guard
// Brief    : Directed bench for the address window guard (window 0x1000_0000..0x2000_0000).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_axi_addr_window_guard;
    import axi_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    axi_req_t      slv_req;
    axi_req_t      mst_req;
    axi_resp_t     slv_rsp;
    axi_resp_t     mst_rsp;
    xbar_rule_64_t rule;
    logic [9:0]    hs_vec;

    int n_vec  = 0;
    int n_fail = 0;

    axi_addr_window_guard #(
        .AxiAddrWidth (32),
        .AxiIdWidth   (4),
        .MaxWrTxns    (2),
        .MaxRdTxns    (2)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .slv_req_i  (slv_req),
        .slv_rsp_o  (slv_rsp),
        .mst_req_o  (mst_req),
        .mst_rsp_i  (mst_rsp),
        .addr_map_i (rule)
    );

    assign hs_vec = {mst_req.aw_valid, mst_req.w_valid, mst_req.b_ready, mst_req.ar_valid,
                     mst_req.r_ready, slv_rsp.aw_ready, slv_rsp.w_ready, slv_rsp.b_valid,
                     slv_rsp.ar_ready, slv_rsp.r_valid};

    typedef struct {
        logic [31:0] aw_addr;
        logic [31:0] ar_addr;
        logic        mst_aw_rdy;
        logic        mst_ar_rdy;
        logic [3:0]  exp;  // {mst aw_valid, slv aw_ready, mst ar_valid, slv ar_ready}
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{32'h1000_0000, 32'h1000_0000, 1'b1, 1'b1, 4'b1111};
        vecs[1] = '{32'h0FFF_FFFF, 32'h1FFF_FFFF, 1'b1, 1'b0, 4'b0110};
        vecs[2] = '{32'h1FFF_FFFF, 32'h2000_0000, 1'b0, 1'b1, 4'b1001};
        vecs[3] = '{32'h2000_0000, 32'h0FFF_FFFC, 1'b1, 1'b1, 4'b0101};
        vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 4'b0101};
        vecs[5] = '{32'h1000_0040, 32'h1800_0000, 1'b0, 1'b1, 4'b1011};

        slv_req = '0;
        mst_rsp = '0;
        rule    = '0;
        rule.start_addr = 64'h1000_0000;
        rule.end_addr   = 64'h2000_0000;

        // Reset with every input busy: all valid/ready outputs must stay low.
        rst = 1'b1;
        slv_req.aw_valid = 1'b1; slv_req.aw.addr = 32'h1000_0000;
        slv_req.ar_valid = 1'b1; slv_req.ar.addr = 32'h1000_0000;
        slv_req.w_valid = 1'b1; slv_req.b_ready = 1'b1; slv_req.r_ready = 1'b1;
        mst_rsp.aw_ready = 1'b1; mst_rsp.w_ready = 1'b1; mst_rsp.b_valid = 1'b1;
        mst_rsp.ar_ready = 1'b1; mst_rsp.r_valid = 1'b1;
        cyc(); cyc();
        chk("reset_handshakes", hs_vec, 10'h0);
        chk("reset_wr_cnt", dut.r_wr_cnt, 0);
        chk("reset_rd_cnt", dut.r_rd_cnt, 0);
        slv_req = '0;
        mst_rsp = '0;
        rst = 1'b0;
        cyc();
        chk("idle_handshakes", hs_vec, 10'h0);

        // Decode table: valids are withdrawn before each edge so no state changes.
        for (int i = 0; i < 6; i++) begin
            slv_req.aw_valid = 1'b1; slv_req.aw.addr = vecs[i].aw_addr;
            slv_req.ar_valid = 1'b1; slv_req.ar.addr = vecs[i].ar_addr;
            mst_rsp.aw_ready = vecs[i].mst_aw_rdy;
            mst_rsp.ar_ready = vecs[i].mst_ar_rdy;
            #1;
            chk($sformatf("decode%0d_aw_ar", i),
                {mst_req.aw_valid, slv_rsp.aw_ready, mst_req.ar_valid, slv_rsp.ar_ready}, vecs[i].exp);
            chk($sformatf("decode%0d_addr_fwd", i), mst_req.aw.addr, vecs[i].aw_addr);
            slv_req.aw_valid = 1'b0; slv_req.ar_valid = 1'b0;
            mst_rsp.aw_ready = 1'b0; mst_rsp.ar_ready = 1'b0;
            cyc();
        end

        // In-window write: AW + 4 W beats forwarded, downstream B returned.
        slv_req.aw.addr = 32'h1000_0040; slv_req.aw.len = 8'd3; slv_req.aw.id = 4'd2;
        slv_req.aw_valid = 1'b1; mst_rsp.aw_ready = 1'b1;
        #1;
        chk("wr_fwd_aw", {mst_req.aw_valid, slv_rsp.aw_ready, mst_req.aw.id}, {1'b1, 1'b1, 4'd2});
        cyc();
        slv_req.aw_valid = 1'b0; mst_rsp.aw_ready = 1'b0;
        chk("wr_fwd_cnt_inc", dut.r_wr_cnt, 1);
        mst_rsp.w_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            logic [31:0] d;
            d = 32'hA000_0000 + 32'(b);
            slv_req.w_valid = 1'b1; slv_req.w.data = d; slv_req.w.last = (b == 3);
            #1;
            chk($sformatf("wr_fwd_w%0d", b), {mst_req.w_valid, slv_rsp.w_ready, mst_req.w.data},
                {1'b1, 1'b1, d});
            cyc();
        end
        slv_req.w_valid = 1'b0; slv_req.w.last = 1'b0; mst_rsp.w_ready = 1'b0;
        mst_rsp.b_valid = 1'b1; mst_rsp.b.id = 4'd2; mst_rsp.b.resp = 2'b00; slv_req.b_ready = 1'b1;
        #1;
        chk("wr_fwd_b", {slv_rsp.b_valid, slv_rsp.b.id, slv_rsp.b.resp, mst_req.b_ready},
            {1'b1, 4'd2, 2'b00, 1'b1});
        cyc();
        mst_rsp.b_valid = 1'b0; slv_req.b_ready = 1'b0;
        chk("wr_fwd_cnt_dec", dut.r_wr_cnt, 0);

        // Out-of-window write: absorbed locally, DECERR one cycle after last W.
        slv_req.aw.addr = 32'h2000_0000; slv_req.aw.len = 8'd1; slv_req.aw.id = 4'd5;
        slv_req.aw_valid = 1'b1; mst_rsp.aw_ready = 1'b1;
        #1;
        chk("wr_err_aw", {mst_req.aw_valid, slv_rsp.aw_ready}, 2'b01);
        cyc();
        slv_req.aw_valid = 1'b0; mst_rsp.aw_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            slv_req.w_valid = 1'b1; slv_req.w.last = (b == 1);
            #1;
            chk($sformatf("wr_err_w%0d", b), {mst_req.w_valid, slv_rsp.w_ready, slv_rsp.b_valid}, 3'b010);
            cyc();
        end
        slv_req.w_valid = 1'b0; slv_req.w.last = 1'b0;
        #1;
        chk("wr_err_b", {slv_rsp.b_valid, slv_rsp.b.id, slv_rsp.b.resp, mst_req.b_ready},
            {1'b1, 4'd5, 2'b11, 1'b0});
        cyc();
        chk("wr_err_b_held", slv_rsp.b_valid, 1);
        slv_req.b_ready = 1'b1;
        cyc();
        slv_req.b_ready = 1'b0;
        #1;
        chk("wr_err_b_done", slv_rsp.b_valid, 0);

        // Out-of-window read: 3 local DECERR beats with a one-cycle stall.
        slv_req.ar.addr = 32'h0FFF_FFFC; slv_req.ar.len = 8'd2; slv_req.ar.id = 4'd7;
        slv_req.ar_valid = 1'b1;
        #1;
        chk("rd_err_ar", {mst_req.ar_valid, slv_rsp.ar_ready, slv_rsp.r_valid}, 3'b010);
        cyc();
        slv_req.ar_valid = 1'b0; slv_req.r_ready = 1'b1;
        #1;
        chk("rd_err_r0", {slv_rsp.r_valid, slv_rsp.r.data, slv_rsp.r.resp, slv_rsp.r.id,
                          slv_rsp.r.last, mst_req.r_ready}, {1'b1, 32'h0, 2'b11, 4'd7, 1'b0, 1'b0});
        cyc();
        slv_req.r_ready = 1'b0;
        #1;
        chk("rd_err_r1", {slv_rsp.r_valid, slv_rsp.r.last}, 2'b10);
        cyc();
        slv_req.r_ready = 1'b1;
        #1;
        chk("rd_err_r1_held", {slv_rsp.r_valid, slv_rsp.r.last}, 2'b10);
        cyc();
        chk("rd_err_r2_last", {slv_rsp.r_valid, slv_rsp.r.last, slv_rsp.r.id}, {1'b1, 1'b1, 4'd7});
        cyc();
        slv_req.r_ready = 1'b0;
        #1;
        chk("rd_err_done", slv_rsp.r_valid, 0);

        // Error AR waits for the outstanding forwarded read to finish.
        slv_req.ar.addr = 32'h1000_0100; slv_req.ar.len = 8'd0; slv_req.ar.id = 4'd1;
        slv_req.ar_valid = 1'b1; mst_rsp.ar_ready = 1'b1;
        #1;
        chk("rd_fwd_ar", {mst_req.ar_valid, slv_rsp.ar_ready}, 2'b11);
        cyc();
        slv_req.ar.addr = 32'h3000_0000; slv_req.ar.id = 4'd9; mst_rsp.ar_ready = 1'b0;
        #1;
        chk("rd_block_ar0", {slv_rsp.ar_ready, mst_req.ar_valid, dut.r_rd_cnt}, {1'b0, 1'b0, 2'd1});
        cyc();
        chk("rd_block_ar1", slv_rsp.ar_ready, 0);
        mst_rsp.r_valid = 1'b1; mst_rsp.r.last = 1'b1; mst_rsp.r.id = 4'd1;
        mst_rsp.r.data = 32'h1234_5678; slv_req.r_ready = 1'b1;
        #1;
        chk("rd_fwd_r", {slv_rsp.r_valid, slv_rsp.r.data, slv_rsp.r.id, mst_req.r_ready, slv_rsp.ar_ready},
            {1'b1, 32'h1234_5678, 4'd1, 1'b1, 1'b0});
        cyc();
        mst_rsp.r = '0; mst_rsp.r_valid = 1'b0;
        #1;
        chk("rd_err_ar_accept", {slv_rsp.ar_ready, dut.r_rd_cnt}, {1'b1, 2'd0});
        cyc();
        slv_req.ar_valid = 1'b0;
        #1;
        chk("rd_err2_r", {slv_rsp.r_valid, slv_rsp.r.id, slv_rsp.r.last, mst_req.r_ready},
            {1'b1, 4'd9, 1'b1, 1'b0});
        cyc();
        slv_req.r_ready = 1'b0;
        #1;
        chk("rd_err2_done", slv_rsp.r_valid, 0);

        // Write limit of 2: third AW stalls until a B; AW and B in one cycle cancel.
        mst_rsp.aw_ready = 1'b1; mst_rsp.w_ready = 1'b1;
        slv_req.aw.len = 8'd0;
        for (int k = 0; k < 2; k++) begin
            slv_req.aw.addr = 32'h1000_0000 + 32'(k * 256); slv_req.aw.id = 4'(k);
            slv_req.aw_valid = 1'b1;
            cyc();
            slv_req.aw_valid = 1'b0; slv_req.w_valid = 1'b1; slv_req.w.last = 1'b1;
            cyc();
            slv_req.w_valid = 1'b0; slv_req.w.last = 1'b0;
        end
        chk("wr_cnt_full", dut.r_wr_cnt, 2);
        slv_req.aw.addr = 32'h1000_0200; slv_req.aw.id = 4'd3; slv_req.aw_valid = 1'b1;
        #1;
        chk("wr_full_stall0", {mst_req.aw_valid, slv_rsp.aw_ready}, 2'b00);
        cyc();
        chk("wr_full_stall1", {mst_req.aw_valid, slv_rsp.aw_ready}, 2'b00);
        mst_rsp.b_valid = 1'b1; mst_rsp.b.id = 4'd0; slv_req.b_ready = 1'b1;
        #1;
        chk("wr_full_b_only", {slv_rsp.aw_ready, slv_rsp.b_valid, mst_req.b_ready}, 3'b011);
        cyc();
        chk("wr_cnt_after_b", dut.r_wr_cnt, 1);
        chk("wr_aw_b_same", {mst_req.aw_valid, slv_rsp.aw_ready, slv_rsp.b_valid}, 3'b111);
        cyc();
        slv_req.aw_valid = 1'b0; mst_rsp.b_valid = 1'b0; slv_req.b_ready = 1'b0;
        chk("wr_cnt_inc_dec", dut.r_wr_cnt, 1);
        slv_req.w_valid = 1'b1; slv_req.w.last = 1'b1;
        cyc();
        slv_req.w_valid = 1'b0; slv_req.w.last = 1'b0;
        mst_rsp.b_valid = 1'b1; slv_req.b_ready = 1'b1;
        cyc();
        mst_rsp.b_valid = 1'b0; slv_req.b_ready = 1'b0;
        chk("wr_cnt_drain", dut.r_wr_cnt, 0);

        // Reset in the middle of an absorbed burst: no DECERR afterwards.
        mst_rsp = '0;
        slv_req.aw.addr = 32'h0000_1000; slv_req.aw.len = 8'd3; slv_req.aw.id = 4'd6;
        slv_req.aw_valid = 1'b1;
        cyc();
        slv_req.aw_valid = 1'b0; slv_req.w_valid = 1'b1; slv_req.w.last = 1'b0;
        #1;
        chk("rst_pre_w_ready", slv_rsp.w_ready, 1);
        cyc();
        rst = 1'b1;
        #1;
        chk("rst_mid_handshakes", hs_vec, 10'h0);
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_after_w_gated", {slv_rsp.w_ready, slv_rsp.b_valid}, 2'b00);
        slv_req.w.last = 1'b1;
        cyc();
        slv_req.w_valid = 1'b0; slv_req.w.last = 1'b0;
        chk("rst_no_b0", slv_rsp.b_valid, 0);
        cyc();
        chk("rst_no_b1", slv_rsp.b_valid, 0);
        slv_req.aw.addr = 32'h1000_0000; slv_req.aw_valid = 1'b1; mst_rsp.aw_ready = 1'b1;
        #1;
        chk("rst_fsm_idle", {mst_req.aw_valid, dut.r_wr_cnt}, {1'b1, 2'd0});
        slv_req.aw_valid = 1'b0; mst_rsp.aw_ready = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
